// File: rtl/scan_mux_pkg.sv
// Shared definitions for the scan_mux block.
//   mode_e : encoding of the mode input and of the FSM state
//            (MODE_MANUAL = 0, MODE_SCAN = 1).
//   clog2  : ceiling log2 with a floor of 1, used to size channel selects.
package scan_mux_pkg;

    typedef enum logic {
        MODE_MANUAL = 1'b0,
        MODE_SCAN   = 1'b1
    } mode_e;

    // A one-bit select is kept even for degenerate counts so that ports
    // never collapse to zero width.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        if (r < 1) begin
            r = 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/scan_ctr.sv
// Scan sequencer for scan_mux: dwell counter, current scan channel and
// wrap detection.
//   clk, reset : clock and asynchronous active-high reset
//   load       : scan entry; channel takes start and the dwell count restarts
//   step       : one enabled cycle spent in scan
//   start      : channel to begin scanning from (already range-checked)
//   chan       : channel for the capture happening on this edge (combinational)
//   wrap       : this edge moves the scan from NCH-1 back to 0 (combinational)
// The dwell register counts cycles already spent on the channel minus one,
// so the entry cycle itself is the first cycle of the first channel.
module scan_ctr
    import scan_mux_pkg::*;
#(
    parameter int NCH  = 4,
    parameter int HOLD = 4,
    parameter int SELW = clog2(NCH)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic            step,
    input  logic [SELW-1:0] start,
    output logic [SELW-1:0] chan,
    output logic            wrap
);

    localparam logic [7:0]      CNT_LAST = 8'(HOLD - 1);
    localparam logic [SELW-1:0] CH_LAST  = SELW'(NCH - 1);

    logic [SELW-1:0] chan_q;
    logic [7:0]      cnt_q;
    logic [SELW-1:0] chan_n;
    logic [7:0]      cnt_n;
    logic            wrap_n;

    always_comb begin
        chan_n = chan_q;
        cnt_n  = cnt_q;
        wrap_n = 1'b0;
        if (load) begin
            chan_n = start;
            cnt_n  = '0;
        end else if (step) begin
            if (cnt_q == CNT_LAST) begin
                cnt_n = '0;
                if (chan_q == CH_LAST) begin
                    chan_n = '0;
                    wrap_n = 1'b1;
                end else begin
                    chan_n = chan_q + SELW'(1);
                end
            end else begin
                cnt_n = cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chan_q <= '0;
            cnt_q  <= '0;
        end else begin
            chan_q <= chan_n;
            cnt_q  <= cnt_n;
        end
    end

    assign chan = chan_n;
    assign wrap = wrap_n;

endmodule

// File: rtl/scan_mux.sv
// Registered channel multiplexer with a manual select mode and an
// automatic round-robin scan mode.
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset
//   din   : NCH packed channels, channel k = din[k*WIDTH +: WIDTH]
//   sel   : manual channel select, also the scan start channel
//   mode  : 0 = manual, 1 = scan
//   en    : capture enable; low freezes every register
//   dout  : captured channel data
//   ch    : channel that produced dout
//   valid : dout holds a legal capture
//   wrap  : one-cycle pulse on the first capture of channel 0 after NCH-1
//   err   : manual select was out of range on the last capture
// The capture on each enabled edge follows the mode being entered, so a
// mode change is visible in the very capture that switches the FSM.
module scan_mux
    import scan_mux_pkg::*;
#(
    parameter  int WIDTH = 3,
    parameter  int NCH   = 4,
    parameter  int HOLD  = 4,
    localparam int SELW  = clog2(NCH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NCH*WIDTH-1:0] din,
    input  logic [SELW-1:0]      sel,
    input  logic                 mode,
    input  logic                 en,
    output logic [WIDTH-1:0]     dout,
    output logic [SELW-1:0]      ch,
    output logic                 valid,
    output logic                 wrap,
    output logic                 err
);

    localparam logic [SELW:0] NCH_X = (SELW + 1)'(NCH);

    mode_e           state_q;
    mode_e           state_n;
    mode_e           mode_in;
    logic            sel_bad;
    logic [SELW-1:0] start;
    logic            load;
    logic            step;
    logic [SELW-1:0] scan_chan;
    logic            scan_wrap;
    logic [SELW-1:0] src;
    logic [WIDTH-1:0] picked;
    logic [WIDTH-1:0] chans [NCH];

    logic [WIDTH-1:0] dout_n;
    logic [SELW-1:0]  ch_n;
    logic             valid_n;
    logic             wrap_n;
    logic             err_n;

    for (genvar k = 0; k < NCH; k++) begin : g_unpack
        assign chans[k] = din[k*WIDTH +: WIDTH];
    end

    assign mode_in = mode_e'(mode);
    assign sel_bad = ({1'b0, sel} >= NCH_X);
    assign start   = sel_bad ? '0 : sel;
    assign load    = en && (mode_in == MODE_SCAN) && (state_q == MODE_MANUAL);
    assign step    = en && (mode_in == MODE_SCAN) && (state_q == MODE_SCAN);

    scan_ctr #(
        .NCH  (NCH),
        .HOLD (HOLD),
        .SELW (SELW)
    ) u_ctr (
        .clk   (clk),
        .reset (reset),
        .load  (load),
        .step  (step),
        .start (start),
        .chan  (scan_chan),
        .wrap  (scan_wrap)
    );

    // Out-of-range manual selects never reach this mux as a capture, so an
    // unmatched src simply yields zero.
    assign src = (mode_in == MODE_SCAN) ? scan_chan : sel;

    always_comb begin
        picked = '0;
        for (int k = 0; k < NCH; k++) begin
            if (src == SELW'(k)) begin
                picked = chans[k];
            end
        end
    end

    always_comb begin
        state_n = state_q;
        dout_n  = dout;
        ch_n    = ch;
        valid_n = valid;
        err_n   = err;
        wrap_n  = 1'b0;
        if (en) begin
            state_n = mode_in;
            if (mode_in == MODE_SCAN) begin
                dout_n  = picked;
                ch_n    = scan_chan;
                valid_n = 1'b1;
                err_n   = 1'b0;
                wrap_n  = scan_wrap;
            end else if (sel_bad) begin
                dout_n  = '0;
                ch_n    = '0;
                valid_n = 1'b0;
                err_n   = 1'b1;
            end else begin
                dout_n  = picked;
                ch_n    = sel;
                valid_n = 1'b1;
                err_n   = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= MODE_MANUAL;
        end else begin
            state_q <= state_n;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dout  <= '0;
            ch    <= '0;
            valid <= 1'b0;
            wrap  <= 1'b0;
            err   <= 1'b0;
        end else begin
            dout  <= dout_n;
            ch    <= ch_n;
            valid <= valid_n;
            wrap  <= wrap_n;
            err   <= err_n;
        end
    end

endmodule

// File: tb/tb_scan_mux.sv
module tb_scan_mux;

    logic        clk;
    logic        reset;
    logic [11:0] din;
    logic [1:0]  sel;
    logic        mode;
    logic        en;
    logic [2:0]  dout;
    logic [1:0]  ch;
    logic        valid;
    logic        wrap;
    logic        err;

    logic [8:0]  din_b;
    logic [1:0]  sel_b;
    logic        mode_b;
    logic [2:0]  dout_b;
    logic [1:0]  ch_b;
    logic        valid_b;
    logic        wrap_b;
    logic        err_b;

    int total;
    int bad;

    scan_mux #(.WIDTH(3), .NCH(4), .HOLD(2)) u_dut (
        .clk   (clk),
        .reset (reset),
        .din   (din),
        .sel   (sel),
        .mode  (mode),
        .en    (en),
        .dout  (dout),
        .ch    (ch),
        .valid (valid),
        .wrap  (wrap),
        .err   (err)
    );

    scan_mux #(.WIDTH(3), .NCH(3), .HOLD(2)) u_dut3 (
        .clk   (clk),
        .reset (reset),
        .din   (din_b),
        .sel   (sel_b),
        .mode  (mode_b),
        .en    (en),
        .dout  (dout_b),
        .ch    (ch_b),
        .valid (valid_b),
        .wrap  (wrap_b),
        .err   (err_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total = total + 1;
        if (got !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0d, want %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int scan_ch [13] = '{2, 2, 3, 3, 0, 0, 1, 1, 2, 2, 3, 3, 0};
    int scan_wr [13] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1};
    int post_ch [6]  = '{0, 1, 1, 2, 2, 3};

    initial begin
        total  = 0;
        bad    = 0;
        reset  = 1'b0;
        en     = 1'b1;
        mode   = 1'b0;
        sel    = 2'd0;
        din    = {3'd4, 3'd3, 3'd2, 3'd1};
        din_b  = {3'd7, 3'd6, 3'd5};
        sel_b  = 2'd0;
        mode_b = 1'b0;

        // asynchronous clear, observed before the first clock edge
        #2 reset = 1'b1;
        #1;
        check_eq("async_dout", dout, 0);
        check_eq("async_valid", valid, 0);
        check_eq("async_ch", ch, 0);
        check_eq("async_wrap", wrap, 0);
        check_eq("async_err", err, 0);
        tick();
        tick();
        check_eq("rst_dout", dout, 0);
        check_eq("rst_valid", valid, 0);
        reset = 1'b0;

        // manual selection, one cycle latency
        for (int i = 0; i < 4; i++) begin
            sel = 2'(i);
            tick();
            check_eq($sformatf("man_dout%0d", i), dout, i + 1);
            check_eq($sformatf("man_ch%0d", i), ch, i);
            check_eq($sformatf("man_valid%0d", i), valid, 1);
            check_eq($sformatf("man_err%0d", i), err, 0);
        end

        // scan from channel 2; sel changes mid-scan must be ignored
        sel  = 2'd2;
        mode = 1'b1;
        for (int i = 0; i < 13; i++) begin
            tick();
            if (i == 0) sel = 2'd0;
            check_eq($sformatf("scan_ch%0d", i), ch, scan_ch[i]);
            check_eq($sformatf("scan_dout%0d", i), dout, scan_ch[i] + 1);
            check_eq($sformatf("scan_wrap%0d", i), wrap, scan_wr[i]);
            check_eq($sformatf("scan_valid%0d", i), valid, 1);
        end

        // enable low right after a wrap: everything frozen, wrap drops
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq($sformatf("frz_ch%0d", i), ch, 0);
            check_eq($sformatf("frz_dout%0d", i), dout, 1);
            check_eq($sformatf("frz_wrap%0d", i), wrap, 0);
        end
        en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check_eq($sformatf("res_ch%0d", i), ch, post_ch[i]);
            check_eq($sformatf("res_wrap%0d", i), wrap, 0);
        end

        // mid-scan reset at ch=3, restart from sel afterwards
        reset = 1'b1;
        sel   = 2'd1;
        #1;
        check_eq("mid_rst_dout", dout, 0);
        check_eq("mid_rst_ch", ch, 0);
        check_eq("mid_rst_valid", valid, 0);
        tick();
        reset = 1'b0;
        tick();
        check_eq("restart_ch0", ch, 1);
        check_eq("restart_dout0", dout, 2);
        tick();
        check_eq("restart_ch1", ch, 1);
        tick();
        check_eq("restart_ch2", ch, 2);
        check_eq("restart_dout2", dout, 3);

        // back to manual
        mode = 1'b0;
        sel  = 2'd3;
        tick();
        check_eq("back_man_ch", ch, 3);
        check_eq("back_man_dout", dout, 4);
        check_eq("back_man_wrap", wrap, 0);

        // three-channel instance: out-of-range select
        sel_b = 2'd3;
        tick();
        check_eq("oor_err", err_b, 1);
        check_eq("oor_valid", valid_b, 0);
        check_eq("oor_dout", dout_b, 0);
        check_eq("oor_ch", ch_b, 0);
        sel_b = 2'd1;
        #1;
        check_eq("oor_err_hold", err_b, 1);
        tick();
        check_eq("oor_err_clr", err_b, 0);
        check_eq("oor_dout_ok", dout_b, 6);
        check_eq("oor_ch_ok", ch_b, 1);
        check_eq("oor_valid_ok", valid_b, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
